// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: packs decoded RV32I fields into instruction words.
// Two-stage valid/ready pipeline; illegal commands become NOP with out_err.

package rv32i_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] addr;
    logic        legal;
  } s1_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } s2_t;

endpackage

module rv32i_instr_encoder
  import rv32i_enc_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        addr_load,
  input  logic [31:0] addr_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  localparam logic [31:0] BASE = {RESET_ADDR[31:2], 2'b00};

  logic        s1_valid;
  logic        s2_valid;
  logic        s2_free;
  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;
  s1_t         s1_q;
  s1_t         s1_d;
  s2_t         s2_q;
  s2_t         s2_d;
  logic [31:0] ctr;
  logic [31:0] load_a;
  logic [31:0] word_a;
  logic        fit12;
  logic        fit13;
  logic        fit21;
  logic        lo12_zero;
  logic        legal;
  logic        addr_lsb_unused;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;

  assign out_valid = s2_valid;
  assign out_instr = s2_q.instr;
  assign out_addr  = s2_q.addr;
  assign out_err   = s2_q.err;

  // signed n-bit fit: every bit from n-1 upward equals the sign
  assign fit12 = (&in_imm[31:11]) || (~|in_imm[31:11]);
  assign fit13 = (&in_imm[31:12]) || (~|in_imm[31:12]);
  assign fit21 = (&in_imm[31:20]) || (~|in_imm[31:20]);
  assign lo12_zero = ~|in_imm[11:0];

  always_comb begin
    legal = 1'b0;
    unique case (in_fmt)
      FMT_R:   legal = 1'b1;
      FMT_I:   legal = fit12;
      FMT_S:   legal = fit12;
      FMT_B:   legal = fit13 && !in_imm[0];
      FMT_U:   legal = lo12_zero;
      FMT_J:   legal = fit21 && !in_imm[0];
      default: legal = 1'b0;
    endcase
  end

  assign load_a = {addr_value[31:2], 2'b00};
  assign word_a = addr_load ? load_a : ctr;
  assign addr_lsb_unused = ^addr_value[1:0];

  always_comb begin
    s1_d       = '0;
    s1_d.fmt   = in_fmt;
    s1_d.op    = in_opcode;
    s1_d.rd    = in_rd;
    s1_d.rs1   = in_rs1;
    s1_d.rs2   = in_rs2;
    s1_d.f3    = in_funct3;
    s1_d.f7    = in_funct7;
    s1_d.imm   = in_imm;
    s1_d.addr  = word_a;
    s1_d.legal = legal;
  end

  always_comb begin
    s2_d       = '0;
    s2_d.addr  = s1_q.addr;
    s2_d.err   = !s1_q.legal;
    s2_d.instr = NOP;
    if (s1_q.legal) begin
      unique case (s1_q.fmt)
        FMT_R: s2_d.instr = {s1_q.f7, s1_q.rs2, s1_q.rs1,
                             s1_q.f3, s1_q.rd, s1_q.op};
        FMT_I: s2_d.instr = {s1_q.imm[11:0], s1_q.rs1,
                             s1_q.f3, s1_q.rd, s1_q.op};
        FMT_S: s2_d.instr = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1,
                             s1_q.f3, s1_q.imm[4:0], s1_q.op};
        FMT_B: s2_d.instr = {s1_q.imm[12], s1_q.imm[10:5],
                             s1_q.rs2, s1_q.rs1, s1_q.f3,
                             s1_q.imm[4:1], s1_q.imm[11], s1_q.op};
        FMT_U: s2_d.instr = {s1_q.imm[31:12], s1_q.rd, s1_q.op};
        FMT_J: s2_d.instr = {s1_q.imm[20], s1_q.imm[10:1],
                             s1_q.imm[11], s1_q.imm[19:12],
                             s1_q.rd, s1_q.op};
        default: s2_d.instr = NOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr <= BASE;
    end else if (in_fire) begin
      ctr <= word_a + 32'd4;
    end else if (addr_load) begin
      ctr <= load_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_q     <= s2_d;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_fire && s2_q.err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb_rv32i_instr_encoder: directed table plus random stream against
// an arithmetic encoding model and decoder round-trip.

module tb_rv32i_instr_encoder;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] err_cnt;

  rv32i_instr_encoder #(.RESET_ADDR(RESET_ADDR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm),
    .addr_load(addr_load), .addr_value(addr_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } exp_t;

  exp_t        q[$];
  vec_t        tbl [15];
  int          checks;
  int          failures;
  int          rdy_mode;
  logic        dir_en;
  logic [31:0] dir_instr;
  logic        dir_err;

  int bnd [18] = '{-2049, -2048, 2047, 2048, -4098, -4096, 4094, 4095,
                   4096, -1048578, -1048576, 1048574, 1048575, 1048576,
                   0, 1, -1, 3};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] x,
                                      input int hi, input int lo);
    return (x >> lo) % (32'd1 << (hi - lo + 1));
  endfunction

  // {err, word} from the format rules, built by shifting fields into place
  function automatic logic [32:0] model(input cmd_t c);
    int          v;
    logic        ok;
    logic [31:0] w;
    v = $signed(c.imm);
    case (c.fmt)
      3'd0:    ok = 1'b1;
      3'd1,
      3'd2:    ok = (v >= -2048) && (v <= 2047);
      3'd3:    ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      3'd4:    ok = (c.imm % 32'd4096) == 32'd0;
      3'd5:    ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 32'h0000_0013};
    w = 32'(c.op);
    case (c.fmt)
      3'd0: w = w + (32'(c.rd) << 7) + (32'(c.f3) << 12)
              + (32'(c.rs1) << 15) + (32'(c.rs2) << 20)
              + (32'(c.f7) << 25);
      3'd1: w = w + (32'(c.rd) << 7) + (32'(c.f3) << 12)
              + (32'(c.rs1) << 15) + (fld(c.imm, 11, 0) << 20);
      3'd2: w = w + (fld(c.imm, 4, 0) << 7) + (32'(c.f3) << 12)
              + (32'(c.rs1) << 15) + (32'(c.rs2) << 20)
              + (fld(c.imm, 11, 5) << 25);
      3'd3: w = w + (fld(c.imm, 11, 11) << 7) + (fld(c.imm, 4, 1) << 8)
              + (32'(c.f3) << 12) + (32'(c.rs1) << 15)
              + (32'(c.rs2) << 20) + (fld(c.imm, 10, 5) << 25)
              + (fld(c.imm, 12, 12) << 31);
      3'd4: w = w + (32'(c.rd) << 7) + (fld(c.imm, 31, 12) << 12);
      default: w = w + (32'(c.rd) << 7) + (fld(c.imm, 19, 12) << 12)
              + (fld(c.imm, 11, 11) << 20) + (fld(c.imm, 10, 1) << 21)
              + (fld(c.imm, 20, 20) << 31);
    endcase
    return {1'b0, w};
  endfunction

  // immediate as the decoder extracts it
  function automatic logic [31:0] dec_imm(input logic [31:0] w,
                                          input logic [2:0] f);
    case (f)
      3'd1: return {{20{w[31]}}, w[31:20]};
      3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: return {w[31:12], 12'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20],
                       w[30:21], 1'b0};
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] w, input logic e);
    vec_t v;
    v.c.fmt = f;   v.c.op = op;   v.c.rd = rd;   v.c.rs1 = rs1;
    v.c.rs2 = rs2; v.c.f3 = f3;   v.c.f7 = f7;   v.c.imm = imm;
    v.instr = w;   v.err = e;
    return v;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t        c;
    int unsigned r;
    r = $urandom % 16;
    c.fmt = (r < 14) ? 3'(r % 6) : 3'(6 + r % 2);
    c.op  = 7'($urandom);
    c.rd  = 5'($urandom);
    c.rs1 = 5'($urandom);
    c.rs2 = 5'($urandom);
    c.f3  = 3'($urandom);
    c.f7  = 7'($urandom);
    case ($urandom % 4)
      0: c.imm = $urandom;
      1: c.imm = 32'(bnd[$urandom % 18]);
      2: c.imm = 32'($urandom_range(0, 8190)) - 32'd4096;
      default: c.imm = $urandom & 32'hFFFF_F000;
    endcase
    return c;
  endfunction

  task automatic monitor();
    exp_t        e;
    cmd_t        c;
    logic [32:0] m;
    logic [31:0] ctr_m;
    logic [31:0] la;
    logic [15:0] cnt_m;
    logic        stall;
    logic        after_rst;
    logic [31:0] p_instr;
    logic [31:0] p_addr;
    logic        p_err;
    ctr_m = RESET_ADDR; cnt_m = '0; stall = 1'b0; after_rst = 1'b0;
    p_instr = '0; p_addr = '0; p_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        ctr_m = RESET_ADDR;
        cnt_m = '0;
        stall = 1'b0;
        after_rst = 1'b1;
      end else begin
        if (after_rst) chk("post_reset_valid", out_valid, 1'b0);
        after_rst = 1'b0;
        chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
        chk("err_cnt", err_cnt, cnt_m);
        if (stall) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_instr", out_instr, p_instr);
          chk("stall_addr", out_addr, p_addr);
          chk("stall_err", out_err, p_err);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("out_without_cmd", out_valid, 1'b0);
          end else begin
            e = q.pop_front();
            chk("out_instr", out_instr, e.instr);
            chk("out_addr", out_addr, e.addr);
            chk("out_err", out_err, e.err);
            if (!e.err && e.fmt >= 3'd1 && e.fmt <= 3'd5)
              chk("round_trip_imm", dec_imm(out_instr, e.fmt), e.imm);
            if (e.err && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
          end
        end
        stall   = out_valid && !out_ready;
        p_instr = out_instr;
        p_addr  = out_addr;
        p_err   = out_err;
        la = addr_value - (addr_value % 32'd4);
        if (in_valid && in_ready) begin
          c.fmt = in_fmt;    c.op = in_opcode; c.rd = in_rd;
          c.rs1 = in_rs1;    c.rs2 = in_rs2;   c.f3 = in_funct3;
          c.f7 = in_funct7;  c.imm = in_imm;
          m = model(c);
          e.instr = dir_en ? dir_instr : m[31:0];
          e.err   = dir_en ? dir_err : m[32];
          e.fmt   = c.fmt;
          e.imm   = c.imm;
          e.addr  = addr_load ? la : ctr_m;
          ctr_m   = e.addr + 32'd4;
          q.push_back(e);
        end else if (addr_load) begin
          ctr_m = la;
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input cmd_t c, input logic de, input logic [31:0] dw,
                      input logic dee, input logic ld,
                      input logic [31:0] lv);
    logic ok;
    in_fmt = c.fmt;   in_opcode = c.op;  in_rd = c.rd;
    in_rs1 = c.rs1;   in_rs2 = c.rs2;    in_funct3 = c.f3;
    in_funct7 = c.f7; in_imm = c.imm;
    dir_en = de; dir_instr = dw; dir_err = dee;
    addr_load = ld; addr_value = lv;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accept", ok, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    addr_load = 1'b0;
    dir_en = 1'b0;
  endtask

  task automatic send_vec(input vec_t v, input logic ld,
                          input logic [31:0] lv);
    send(v.c, 1'b1, v.instr, v.err, ld, lv);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; rdy_mode = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    addr_load = 1'b0; addr_value = '0;
    dir_en = 1'b0; dir_instr = '0; dir_err = 1'b0;

    tbl[0]  = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
                 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    tbl[1]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
                 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    tbl[2]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h0000_0800, 32'h0010_00EF, 1'b0);
    tbl[3]  = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
                 32'h0000_0800, 32'h0000_0013, 1'b1);
    tbl[4]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
                 32'h0000_0003, 32'h0000_0013, 1'b1);
    tbl[5]  = mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0,
                 32'h0000_0000, 32'h0000_0013, 1'b1);
    tbl[6]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20,
                 32'h0000_0000, 32'h4020_81B3, 1'b0);
    tbl[7]  = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,
                 32'h0000_0008, 32'h0020_A423, 1'b0);
    tbl[8]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h1234_5000, 32'h1234_52B7, 1'b0);
    tbl[9]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h1234_5001, 32'h0000_0013, 1'b1);
    tbl[10] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    tbl[11] = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0);
    tbl[12] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0,
                 32'hFFFF_F000, 32'h8000_1063, 1'b0);
    tbl[13] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0,
                 32'h0000_1000, 32'h0000_0013, 1'b1);
    tbl[14] = mk(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h0000_0000, 32'h0000_0013, 1'b1);

    fork
      monitor();
      ready_drv();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_instr", out_instr, 32'h0);
    chk("reset_out_addr", out_addr, 32'h0);
    chk("reset_out_err", out_err, 1'b0);
    chk("reset_err_cnt", err_cnt, 16'h0);
    chk("reset_in_ready", in_ready, 1'b1);

    send_vec(tbl[0], 1'b0, 32'h0);
    chk("latency_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("latency_valid", out_valid, 1'b1);
    chk("latency_instr", out_instr, 32'hFFF1_0093);
    chk("latency_addr", out_addr, RESET_ADDR);

    for (int i = 1; i < 6; i++) send_vec(tbl[i], 1'b0, 32'h0);
    drain();
    chk("illegal_err_cnt", err_cnt, 16'd3);

    for (int i = 6; i < 15; i++) send_vec(tbl[i], 1'b0, 32'h0);
    drain();

    rdy_mode = 1;
    repeat (8) send(rnd_cmd(), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    send_vec(tbl[6], 1'b1, 32'h0000_1003);
    @(posedge clk);
    #1;
    chk("load_addr", out_addr, 32'h0000_1000);
    send_vec(tbl[7], 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("load_next_addr", out_addr, 32'h0000_1004);
    send_vec(tbl[8], 1'b1, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("wrap_top_addr", out_addr, 32'hFFFF_FFFC);
    send_vec(tbl[10], 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("wrap_zero_addr", out_addr, 32'h0000_0000);
    drain();

    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_vec(tbl[3], 1'b0, 32'h0);
    send_vec(tbl[7], 1'b0, 32'h0);
    chk("full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_err_cnt", err_cnt, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("flush_still_empty", out_valid, 1'b0);
    send_vec(tbl[0], 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("flush_next_valid", out_valid, 1'b1);
    chk("flush_next_addr", out_addr, RESET_ADDR);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
      if ($urandom % 16 == 0)
        send(rnd_cmd(), 1'b0, 32'h0, 1'b0, 1'b1, $urandom);
      else
        send(rnd_cmd(), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_encoder.md
# rv32i_instr_encoder

Streaming RV32I instruction encoder: the inverse of the decoder's immediate and field extraction. It accepts decoded fields (format, opcode, registers, funct3/funct7, full 32-bit immediate) over a valid/ready handshake. It range-checks the immediate and packs it into the R/I/S/B/U/J bit layout. It emits the 32-bit word with an auto-incrementing word address. It sits between the test/boot sequencer and the instruction-memory write port, and its output must round-trip exactly through the decoder's I/S/B/U/J immediate functions.

## Interface
- RESET_ADDR, 32'h0000_0000: address counter value after reset; bits [1:0] forced to 0.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input command valid
- in_ready  out  1  encoder can accept a command this cycle
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 are illegal
- in_opcode  in  7  opcode, passed to bits [6:0] unchanged
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3; in_funct7  in  7  funct7 (R only)
- in_imm  in  32  immediate as the decoder would return it (sign-extended value)
- addr_load  in  1  load address counter; addr_value  in  32  value to load
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  32  word address of out_instr
- out_err  out  1  word was rejected and replaced by NOP
- err_cnt  out  16  saturating count of rejected words

## Operation
- Two-stage pipeline. S1 captures the command and the address, and computes the legality check. S2 holds the packed word, address, and error flag.
- Encoding, with op = in_opcode:
  - R: {funct7, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Legality, with the immediate treated as signed:
  - R is always legal.
  - I/S: -2048 ≤ imm ≤ 2047.
  - B: -4096 ≤ imm ≤ 4094 and imm[0]=0.
  - U: imm[11:0]=0.
  - J: -1048576 ≤ imm ≤ 1048574 and imm[0]=0.
  - fmt 6/7 are illegal.
- Illegal command: out_instr=32'h0000_0013 (addi x0,x0,0) and out_err=1. The word still consumes an address. err_cnt increments on the S2 output handshake, saturating at 16'hFFFF.
- Address counter: on each input handshake the word takes the current counter value, and the counter advances by 4 (32-bit wrap, 32'hFFFF_FFFC → 0).
- addr_load sets the counter to {addr_value[31:2], 2'b00}.
- addr_load in the same cycle as an input handshake: the accepted word gets the loaded value, and the counter becomes loaded+4.

## Timing
- Reset values:
  - in_ready=1 (combinational; stages empty)
  - out_valid=0, out_instr=0, out_addr=0, out_err=0
  - err_cnt=0
  - counter=RESET_ADDR
  - both stage valids=0
- Reset mid-operation discards in-flight words without emitting them. err_cnt is cleared.
- Latency: command accepted at edge N → out_valid=1 after edge N+1 (two register stages, 1 cycle through each). Throughput is 1 word/cycle when out_ready=1.
- Handshake rules:
  - s2_free = !s2_valid | out_ready
  - S1 advances into S2 when s1_valid & s2_free
  - in_ready = !s1_valid | s2_free
- in_ready has no combinational path from in_valid; it may depend combinationally on out_ready.
- While out_valid & !out_ready: out_instr, out_addr and out_err hold stable, and out_valid stays 1.
- Full pipeline (both stages valid, out_ready=0): in_ready=0. No command is dropped or duplicated.
- Simultaneous S2 drain and S1 refill in one cycle is allowed: no bubble.

## Test plan
- I round-trip: fmt=I, op=0010011, rd=1, rs1=2, f3=0, imm=-1 → out_instr=32'hFFF1_0093, out_addr=RESET_ADDR, out_err=0, 2 cycles after accept.
- B/J scrambling:
  - fmt=B, op=1100011, rs1=1, rs2=2, f3=0, imm=-4 → 32'hFE20_8EE3.
  - fmt=J, op=1101111, rd=1, imm=2048 → 32'h0010_00EF.
  - The decoder's B_imm/J_imm functions return -4 and 2048.
- Illegal: fmt=I imm=2048, fmt=B imm=3, fmt=7 → three words 32'h0000_0013 with out_err=1, err_cnt=3, addresses still +4 apart.
- Backpressure: stream 8 commands with out_ready toggled pseudo-randomly → exactly 8 words, in order, addresses RESET_ADDR..+28, outputs stable while stalled, in_ready=0 only when both stages full.
- Address control: addr_load=1 with addr_value=32'h0000_1003 in the same cycle as an accept → that word's out_addr=32'h0000_1000, next word 32'h0000_1004. A load from 32'hFFFF_FFFC wraps to 0.
- Reset with 2 words in flight → no out_valid after reset, err_cnt=0, next word's out_addr=RESET_ADDR.
